// File: rtl/alu_control_mdu.sv
// alu_control_mdu: ALU control decoder plus an iterative unsigned multiply/divide unit.
//
// Ports:
//   i_clk, i_rst_n        rising-edge clock, synchronous active-low reset
//   i_alu_op, i_funct     op class and funct field; decoded combinationally to o_alu_ctrl/o_illegal
//   i_issue               instruction in EX is valid; starts MULTU/DIVU when idle
//   i_flush               cancels an in-flight multiply/divide, blocks a same-cycle start
//   i_src_a, i_src_b      multiplicand/dividend and multiplier/divisor
//   o_busy                multiply/divide in flight (stall request)
//   o_done, o_div0        one-cycle pulses after HI/LO are written (div0: divisor was zero)
//   o_hi, o_lo            HI/LO result registers
module alu_control_mdu #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned FUNCT_W = 6
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [1:0]         i_alu_op,
    input  logic [FUNCT_W-1:0] i_funct,
    input  logic               i_issue,
    input  logic               i_flush,
    input  logic [WIDTH-1:0]   i_src_a,
    input  logic [WIDTH-1:0]   i_src_b,
    output logic [3:0]         o_alu_ctrl,
    output logic               o_illegal,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_div0,
    output logic [WIDTH-1:0]   o_hi,
    output logic [WIDTH-1:0]   o_lo
);

    localparam int unsigned      CNT_W   = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);
    localparam logic [FUNCT_W-1:0] F_ADD   = FUNCT_W'(6'b100000);
    localparam logic [FUNCT_W-1:0] F_SUB   = FUNCT_W'(6'b100010);
    localparam logic [FUNCT_W-1:0] F_AND   = FUNCT_W'(6'b100100);
    localparam logic [FUNCT_W-1:0] F_OR    = FUNCT_W'(6'b100101);
    localparam logic [FUNCT_W-1:0] F_SLT   = FUNCT_W'(6'b101010);
    localparam logic [FUNCT_W-1:0] F_NOR   = FUNCT_W'(6'b100111);
    localparam logic [FUNCT_W-1:0] F_MFHI  = FUNCT_W'(6'b010000);
    localparam logic [FUNCT_W-1:0] F_MFLO  = FUNCT_W'(6'b010010);
    localparam logic [FUNCT_W-1:0] F_MULTU = FUNCT_W'(6'b011001);
    localparam logic [FUNCT_W-1:0] F_DIVU  = FUNCT_W'(6'b011011);

    typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_a;     // multiplicand, or dividend shifting into quotient
    logic [WIDTH-1:0] r_b;     // multiplier (shifts out LSB-first, receives product low), or divisor
    logic [WIDTH-1:0] r_part;  // product high half, or partial remainder
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;
    logic             r_div0;

    logic w_is_multu;
    logic w_is_divu;
    logic w_start;
    logic w_last;

    // ---------------- decode ----------------
    always_comb begin
        o_alu_ctrl = 4'b1111;
        o_illegal  = 1'b1;
        case (i_alu_op)
            2'b00: begin o_alu_ctrl = 4'b0010; o_illegal = 1'b0; end
            2'b01: begin o_alu_ctrl = 4'b0110; o_illegal = 1'b0; end
            2'b10: begin
                o_illegal = 1'b0;
                case (i_funct)
                    F_ADD:   o_alu_ctrl = 4'b0010;
                    F_SUB:   o_alu_ctrl = 4'b0110;
                    F_AND:   o_alu_ctrl = 4'b0000;
                    F_OR:    o_alu_ctrl = 4'b0001;
                    F_SLT:   o_alu_ctrl = 4'b0111;
                    F_NOR:   o_alu_ctrl = 4'b1100;
                    F_MFHI:  o_alu_ctrl = 4'b1000;
                    F_MFLO:  o_alu_ctrl = 4'b1001;
                    F_MULTU: o_alu_ctrl = 4'b1010;
                    F_DIVU:  o_alu_ctrl = 4'b1011;
                    default: begin o_alu_ctrl = 4'b1111; o_illegal = 1'b1; end
                endcase
            end
            default: begin o_alu_ctrl = 4'b1111; o_illegal = 1'b1; end
        endcase
    end

    assign w_is_multu = (i_alu_op == 2'b10) && (i_funct == F_MULTU);
    assign w_is_divu  = (i_alu_op == 2'b10) && (i_funct == F_DIVU);
    // flush beats issue, so a flushed cycle never starts anything
    assign w_start    = (r_state == StIdle) && i_issue && !i_flush && (w_is_multu || w_is_divu);
    assign w_last     = (r_cnt == LAST);

    // ---------------- FSM ----------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= StIdle;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_start) w_state_next = w_is_multu ? StMul : StDiv;
            end
            StMul, StDiv: begin
                if (i_flush || w_last) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        o_busy = (r_state != StIdle);
    end

    // ---------------- datapath ----------------
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH-1:0] w_div_diff;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_div_rem;
    logic [WIDTH-1:0] w_div_quo;

    assign w_mul_sum  = {1'b0, r_part} + (r_b[0] ? {1'b0, r_a} : '0);
    assign w_rem_sh   = {r_part, r_a[WIDTH-1]};
    // remainder after a successful subtract is below the divisor, so WIDTH bits suffice
    assign w_div_ge   = (w_rem_sh >= {1'b0, r_b});
    assign w_div_diff = w_rem_sh[WIDTH-1:0] - r_b;
    assign w_div_rem  = w_div_ge ? w_div_diff : w_rem_sh[WIDTH-1:0];
    assign w_div_quo  = {r_a[WIDTH-2:0], w_div_ge};

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_part <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
            r_div0 <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_div0 <= 1'b0;
            if (w_start) begin
                r_a    <= i_src_a;
                r_b    <= i_src_b;
                r_part <= '0;
                r_cnt  <= '0;
            end else if (i_flush) begin
                r_cnt <= '0;
            end else if (r_state == StMul) begin
                // {part, b} shifts right one bit per step; product low bits fill b from the top
                r_part <= w_mul_sum[WIDTH:1];
                r_b    <= {w_mul_sum[0], r_b[WIDTH-1:1]};
                r_cnt  <= r_cnt + CNT_W'(1);
                if (w_last) begin
                    r_hi   <= w_mul_sum[WIDTH:1];
                    r_lo   <= {w_mul_sum[0], r_b[WIDTH-1:1]};
                    r_done <= 1'b1;
                    r_cnt  <= '0;
                end
            end else if (r_state == StDiv) begin
                r_part <= w_div_rem;
                r_a    <= w_div_quo;
                r_cnt  <= r_cnt + CNT_W'(1);
                if (w_last) begin
                    r_hi   <= w_div_rem;
                    r_lo   <= w_div_quo;
                    r_done <= 1'b1;
                    r_div0 <= (r_b == '0);
                    r_cnt  <= '0;
                end
            end
        end
    end

    assign o_done = r_done;
    assign o_div0 = r_div0;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule
